// File: rtl/clz_scan_arbiter.sv
// Time-shared leading-one scanner: round-robin grant among NREQ requesters, CHUNK bits per cycle from the MSB.
// Optional build macro CLZ_ZERO_FAST_EN: an all-zero operand skips the scan and reports on the accept edge.
module clz_scan_arbiter #(
  parameter  int WIDTH  = 32,
  parameter  int CHUNK  = 8,
  parameter  int NREQ   = 2,
  localparam int NCHUNK = WIDTH / CHUNK,
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int IXW    = $clog2(WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [IXW-1:0]        rsp_index,
  output logic                  rsp_zero,
  output logic                  busy
);

  localparam int CPW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   grant;
  logic [IDW-1:0]   next_ptr;
  logic             any_req;
  logic [CPW-1:0]   cptr;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] sel_word;
  logic [CHUNK-1:0] chunk;

  function automatic logic [IXW-1:0] msb_pos(input logic [CHUNK-1:0] c);
    msb_pos = '0;
    for (int b = 0; b < CHUNK; b++) begin
      if (c[b]) msb_pos = IXW'(b);
    end
  endfunction

  // Round-robin search starting at rr_ptr; the first valid requester wins.
  always_comb begin
    int idx;
    idx      = 0;
    grant    = '0;
    any_req  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!any_req && req_valid[idx]) begin
        any_req = 1'b1;
        grant   = IDW'(idx);
      end
    end
  end

  assign next_ptr  = IDW'((int'(grant) + 1) % NREQ);
  assign sel_word  = req_data[int'(grant)*WIDTH +: WIDTH];
  assign chunk     = word[int'(cptr)*CHUNK +: CHUNK];
  assign req_ready = (rst_n && state == S_IDLE && any_req) ? (NREQ'(1) << grant) : '0;
  assign rsp_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  // Operand capture is datapath only and needs no reset.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && any_req) word <= sel_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      cptr      <= '0;
      rsp_id    <= '0;
      rsp_index <= '0;
      rsp_zero  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            rsp_id <= grant;
            rr_ptr <= next_ptr;
            cptr   <= CPW'(NCHUNK - 1);
`ifdef CLZ_ZERO_FAST_EN
            if (sel_word == '0) begin
              rsp_index <= IXW'(WIDTH);
              rsp_zero  <= 1'b1;
              state     <= S_DONE;
            end else begin
              state <= S_SCAN;
            end
`else
            state <= S_SCAN;
`endif
          end
        end
        S_SCAN: begin
          if (chunk != '0) begin
            rsp_index <= IXW'(int'(cptr) * CHUNK) + msb_pos(chunk);
            rsp_zero  <= 1'b0;
            state     <= S_DONE;
          end else if (cptr == '0) begin
            rsp_index <= IXW'(WIDTH);
            rsp_zero  <= 1'b1;
            state     <= S_DONE;
          end else begin
            cptr <= cptr - 1'b1;
          end
        end
        S_DONE: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clz_scan_arbiter.sv
// Bench for clz_scan_arbiter: vector table, hand-written corner sequences and a randomized run against a reference model.
module tb_clz_scan_arbiter;
  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NREQ   = 2;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IXW    = $clog2(WIDTH) + 1;
`ifdef CLZ_ZERO_FAST_EN
  localparam int ZLAT = 0;
`else
  localparam int ZLAT = NCHUNK;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [IDW-1:0]        rsp_id;
  logic [IXW-1:0]        rsp_index;
  logic                  rsp_zero;
  logic                  busy;

  int errors = 0;
  int checks = 0;
  int rr_model = 0;

  clz_scan_arbiter #(.WIDTH(WIDTH), .CHUNK(CHUNK), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_index(rsp_index), .rsp_zero(rsp_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               id;
    logic [WIDTH-1:0] data;
    int               idx;
    int               lat;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Highest set bit by plain search from the top, or WIDTH for zero.
  function automatic int ref_index(input logic [WIDTH-1:0] d);
    for (int b = WIDTH - 1; b >= 0; b--) if (d[b]) return b;
    return WIDTH;
  endfunction

  function automatic int ref_lat(input logic [WIDTH-1:0] d);
    int i;
    i = ref_index(d);
    if (i == WIDTH) return ZLAT;
    return (WIDTH - 1 - i) / CHUNK + 1;
  endfunction

  function automatic logic [NREQ*WIDTH-1:0] rand_data();
    logic [NREQ*WIDTH-1:0] r;
    for (int i = 0; i < NREQ; i++) r[i*WIDTH +: WIDTH] = $urandom;
    return r;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] o;
    o = '0;
    o[i] = 1'b1;
    return o;
  endfunction

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < NCHUNK + 4) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid) begin
      errors++;
      $display("FAIL rsp_timeout: got rsp_valid=0 expected 1 within %0d cycles", NCHUNK + 4);
    end
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("ack_rsp_valid", rsp_valid, 0);
    chk("ack_busy", busy, 0);
  endtask

  // One transaction: expects the given grant, result and latency; caller keeps rr_model in step.
  task automatic run_one(input string tag, input logic [NREQ-1:0] vmask,
                         input logic [NREQ*WIDTH-1:0] dat, input int exp_id,
                         input int exp_idx, input int exp_lat);
    int lat;
    req_valid = vmask;
    req_data  = dat;
    rsp_ready = 1'b1;
    #1;
    chk({tag, "_req_ready"}, req_ready, onehot(exp_id));
    @(posedge clk); #1;
    req_valid = '0;
    req_data  = rand_data();
    wait_rsp(lat);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_id"}, rsp_id, exp_id);
    chk({tag, "_index"}, rsp_index, exp_idx);
    chk({tag, "_zero"}, rsp_zero, exp_idx == WIDTH);
    ack();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_index"}, rsp_index, 0);
    chk({tag, "_rsp_zero"}, rsp_zero, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  vec_t tbl[8];

  initial begin
    logic [NREQ*WIDTH-1:0] d;
    logic [NREQ-1:0]       m;
    int                    g, lat;

    tbl[0] = '{0, 32'h8000_0000, 31, 1};
    tbl[1] = '{1, 32'h0000_0001, 0, 4};
    tbl[2] = '{0, 32'h0000_0000, 32, ZLAT};
    tbl[3] = '{1, 32'h0000_0040, 6, 4};
    tbl[4] = '{0, 32'h00FF_0000, 23, 2};
    tbl[5] = '{1, 32'h0000_8000, 15, 3};
    tbl[6] = '{0, 32'h7FFF_FFFF, 30, 1};
    tbl[7] = '{1, 32'h0100_0000, 24, 1};

    // Reset state, with requests pending
    req_valid = 2'b11;
    #2;
    chk_all_zero("reset");
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Both requesting from rr_ptr=0: id0 first, then id1, then pointer back at 0
    req_valid = 2'b11;
    req_data  = {32'h0000_0100, 32'h0001_0000};
    #1;
    chk("rr_first_ready", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b10;
    chk("rr_scan_ready", req_ready, 2'b00);
    chk("rr_scan_busy", busy, 1);
    wait_rsp(lat);
    chk("rr_first_lat", lat, 2);
    chk("rr_first_id", rsp_id, 0);
    chk("rr_first_index", rsp_index, 16);
    ack();
    chk("rr_second_ready", req_ready, 2'b10);
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(lat);
    chk("rr_second_lat", lat, 3);
    chk("rr_second_id", rsp_id, 1);
    chk("rr_second_index", rsp_index, 8);
    ack();
    req_valid = 2'b11;
    #1;
    chk("rr_wrap_ready", req_ready, 2'b01);
    req_valid = '0;
    @(posedge clk); #1;
    rr_model = 0;

    // Vector table, single requester each
    for (int i = 0; i < 8; i++) begin
      d = rand_data();
      d[tbl[i].id*WIDTH +: WIDTH] = tbl[i].data;
      run_one($sformatf("vec%0d", i), onehot(tbl[i].id), d, tbl[i].id, tbl[i].idx, tbl[i].lat);
      rr_model = (tbl[i].id + 1) % NREQ;
    end

    // Randomized requests against the reference model
    for (int it = 0; it < 60; it++) begin
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      d = rand_data();
      for (int i = 0; i < NREQ; i++) begin
        case ($urandom_range(0, 3))
          0: d[i*WIDTH +: WIDTH] = '0;
          1: d[i*WIDTH +: WIDTH] = d[i*WIDTH +: WIDTH] >> $urandom_range(0, WIDTH - 1);
          default: ;
        endcase
      end
      g = -1;
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && m[(rr_model + k) % NREQ]) g = (rr_model + k) % NREQ;
      run_one($sformatf("rnd%0d", it), m, d, g, ref_index(d[g*WIDTH +: WIDTH]),
              ref_lat(d[g*WIDTH +: WIDTH]));
      rr_model = (g + 1) % NREQ;
    end

    // Response back-pressure: outputs held, no accept while another requester waits
    req_valid = onehot(rr_model);
    req_data  = '0;
    req_data[rr_model*WIDTH +: WIDTH] = 32'h0000_0010;
    rsp_ready = 1'b0;
    g = rr_model;
    @(posedge clk); #1;
    req_valid = '1;
    wait_rsp(lat);
    chk("stall_lat", lat, 4);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("stall_valid", rsp_valid, 1);
      chk("stall_index", rsp_index, 4);
      chk("stall_id", rsp_id, g);
      chk("stall_ready", req_ready, 0);
      chk("stall_busy", busy, 1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release_valid", rsp_valid, 0);
    chk("stall_release_busy", busy, 0);
    chk("stall_release_grant", req_ready, onehot((g + 1) % NREQ));
    req_valid = '0;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a scan
    req_valid = 2'b01;
    req_data  = {32'h0, 32'h0000_0001};
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #3;
    chk("pre_abort_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int c = 0; c < NCHUNK + 2; c++) begin
      @(posedge clk); #1;
      chk("abort_no_rsp", rsp_valid, 0);
    end
    run_one("post_reset", 2'b11, {32'h0000_0001, 32'h0000_0040}, 0, 6, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
